keygen_rng_sched: RTL and testbench
===================================

// Module: keygen_rng_sched
// PURPOSE
//  Sequences the two sparse-polynomial generators (h0 then h1) of key generation and time-shares the single
//  RNG FIFO between them. Sits between the keygen top FSM and the h0/h1 controllers; forwards the active
//  controller's FIFO read/RNG-start, hides the FIFO from the idle one, and enforces a per-phase watchdog.
// PARAMETERS
//  RNG_DAT_W  64  RNG FIFO data width (data bus wired directly to both controllers, not muxed here)
//  TO_W       20  watchdog counter width; a phase times out after 2**TO_W-1 cycles
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous reset, active-high
//  start          in   1          1-cycle pulse; begin h0+h1 generation (ignored unless IDLE)
//  done           out  1          1-cycle pulse; sequence finished (success or error)
//  busy           out  1          high in every state except IDLE
//  err            out  1          sticky watchdog flag; cleared by next accepted start or rst
//  h0_start       out  1          1-cycle start pulse to h0 controller
//  h0_done        in   1          1-cycle done pulse from h0 controller
//  h1_start       out  1          1-cycle start pulse to h1 controller
//  h1_done        in   1          1-cycle done pulse from h1 controller
//  h0_fifo_rd     in   1          FIFO read request from h0
//  h0_rng_start   in   2          RNG start code from h0 (0 off, 1 run, 2 init)
//  h0_fifo_empty  out  1          FIFO empty as seen by h0
//  h1_fifo_rd     in   1          FIFO read request from h1
//  h1_rng_start   in   2          RNG start code from h1
//  h1_fifo_empty  out  1          FIFO empty as seen by h1
//  fifo_rd        out  1          read strobe to RNG FIFO
//  fifo_empty     in   1          RNG FIFO empty
//  rng_start      out  2          RNG start code to RNG core
//  sel            out  2          owner: 0 none, 1 h0, 2 h1 (registered)
// BEHAVIOUR
//  Reset: state IDLE; done, busy, err, h0_start, h1_start, sel = 0; counter = 0.
//  States: IDLE -> RUN0 -> GAP -> RUN1 -> FIN -> IDLE.
//   IDLE: start=1 -> RUN0 next cycle; h0_start=1, err cleared, sel=1 in that cycle (start-to-h0_start = 1 clk).
//   RUN0: h0_done=1 -> GAP. h1_done ignored.
//   GAP : exactly 1 cycle, sel=0 (drains any in-flight h0 read); -> RUN1 with h1_start=1, sel=2.
//   RUN1: h1_done=1 -> FIN. h0_done ignored.
//   FIN : done=1 for 1 cycle, sel=0; -> IDLE. busy stays high in FIN.
//  Mux (combinational from registered sel):
//   fifo_rd   = sel==1 ? h0_fifo_rd : sel==2 ? h1_fifo_rd : 0.
//   rng_start = sel==1 ? h0_rng_start : sel==2 ? h1_rng_start : 0.
//   hX_fifo_empty = fifo_empty when sel selects X, else 1 (non-owner never sees data).
//   Non-owner fifo_rd / rng_start are dropped, never queued.
//  Watchdog: counter cleared on entering RUN0 and RUN1, +1 each cycle in RUN0/RUN1, saturating.
//   Counter reaching 2**TO_W-1 in RUN0/RUN1 (no hX_done same cycle) -> err=1, go FIN (h1 not started if in RUN0).
//   hX_done in the same cycle as timeout: done wins, err stays 0.
//  start while busy: ignored, no effect on state or counter.
//  rst mid-sequence: return to IDLE next edge, all outputs to reset values, err cleared; no done pulse.
//  h0_start/h1_start never both high; done and hX_start never high in the same cycle.
// TESTING
//  T1 nominal: start@c0; h0_done@c50; h1_done@c120 -> h0_start@c1, h1_start@c52, done@c122, err=0.
//  T2 mux isolation: in RUN0 drive h1_fifo_rd=1, h1_rng_start=2 -> fifo_rd=h0_fifo_rd, rng_start=h0 value,
//     h1_fifo_empty=1 throughout; mirror check in RUN1; GAP cycle -> fifo_rd=0, rng_start=0, both empties=1.
//  T3 watchdog: TO_W=4, never assert h0_done -> err=1 and done after 15 cycles in RUN0, h1_start never pulses.
//  T4 done/timeout tie: TO_W=4, h1_done on the 15th RUN1 cycle -> err=0, done next cycle.
//  T5 start while busy: extra start pulses in RUN0/GAP/RUN1/FIN -> no restart, exactly one done.
//  T6 reset mid-RUN1: rst=1 one cycle -> busy=0, sel=0, no done; subsequent start runs T1 sequence cleanly.

Source files
------------

// File: rtl/keygen_rng_sched.sv
// Sequences the h0 then h1 sparse-polynomial generators, time-shares the RNG FIFO
// between them and aborts a phase that stalls past the watchdog limit.
module keygen_rng_sched #(
   parameter int unsigned RNG_DAT_W = 64,
   parameter int unsigned TO_W      = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       done,
   output logic       busy,
   output logic       err,
   output logic       h0_start,
   input  logic       h0_done,
   output logic       h1_start,
   input  logic       h1_done,
   input  logic       h0_fifo_rd,
   input  logic [1:0] h0_rng_start,
   output logic       h0_fifo_empty,
   input  logic       h1_fifo_rd,
   input  logic [1:0] h1_rng_start,
   output logic       h1_fifo_empty,
   output logic       fifo_rd,
   input  logic       fifo_empty,
   output logic [1:0] rng_start,
   output logic [1:0] sel
);

   localparam logic [1:0] SEL_NONE = 2'd0;
   localparam logic [1:0] SEL_H0   = 2'd1;
   localparam logic [1:0] SEL_H1   = 2'd2;
   localparam logic [TO_W-1:0] CNT_MAX = '1;
   // A misconfigured instance never leaves IDLE.
   localparam logic CFG_OK = (RNG_DAT_W > 0) && (TO_W > 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RUN0 = 3'd1,
      GAP  = 3'd2,
      RUN1 = 3'd3,
      FIN  = 3'd4
   } state_t;

   state_t          state, state_n;
   logic [TO_W-1:0] cnt, cnt_n;
   logic            done_n, busy_n, err_n, h0_start_n, h1_start_n;
   logic [1:0]      sel_n;
   logic            timeout;
   logic [TO_W-1:0] cnt_inc;

   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + TO_W'(1);
   // Counter hits its limit on this cycle's increment.
   assign timeout = (cnt == CNT_MAX - TO_W'(1));

   // Next-state and next registered outputs.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      err_n      = err;
      done_n     = 1'b0;
      h0_start_n = 1'b0;
      h1_start_n = 1'b0;
      case (state)
         IDLE: begin
            if (start && CFG_OK) begin
               state_n    = RUN0;
               cnt_n      = '0;
               err_n      = 1'b0;
               h0_start_n = 1'b1;
            end
         end
         RUN0: begin
            cnt_n = cnt_inc;
            if (h0_done) begin
               state_n = GAP;
            end else if (timeout) begin
               state_n = FIN;
               err_n   = 1'b1;
            end
         end
         GAP: begin
            state_n    = RUN1;
            cnt_n      = '0;
            h1_start_n = 1'b1;
         end
         RUN1: begin
            cnt_n = cnt_inc;
            if (h1_done) begin
               state_n = FIN;
            end else if (timeout) begin
               state_n = FIN;
               err_n   = 1'b1;
            end
         end
         FIN: begin
            state_n = IDLE;
            done_n  = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      sel_n  = (state_n == RUN0) ? SEL_H0 :
               (state_n == RUN1) ? SEL_H1 : SEL_NONE;
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
         h0_start <= 1'b0;
         h1_start <= 1'b0;
         sel      <= SEL_NONE;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         done     <= done_n;
         busy     <= busy_n;
         err      <= err_n;
         h0_start <= h0_start_n;
         h1_start <= h1_start_n;
         sel      <= sel_n;
      end
   end

   // FIFO/RNG ownership mux; the idle controller sees an empty FIFO.
   assign fifo_rd       = (sel == SEL_H0) ? h0_fifo_rd :
                          (sel == SEL_H1) ? h1_fifo_rd : 1'b0;
   assign rng_start     = (sel == SEL_H0) ? h0_rng_start :
                          (sel == SEL_H1) ? h1_rng_start : 2'd0;
   assign h0_fifo_empty = (sel == SEL_H0) ? fifo_empty : 1'b1;
   assign h1_fifo_empty = (sel == SEL_H1) ? fifo_empty : 1'b1;

endmodule

// File: tb/tb_keygen_rng_sched.sv
// Directed bench for keygen_rng_sched: nominal, mux isolation, watchdog, tie,
// start-while-busy and mid-run reset, with a done-event scoreboard.
module tb_keygen_rng_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       h0_done = 1'b0, h1_done = 1'b0;
   logic       h0_fifo_rd = 1'b0, h1_fifo_rd = 1'b0;
   logic [1:0] h0_rng_start = 2'd0, h1_rng_start = 2'd0;
   logic       fifo_empty = 1'b1;

   logic       done, busy, err, h0_start, h1_start, h0_fifo_empty, h1_fifo_empty, fifo_rd;
   logic [1:0] rng_start, sel;
   logic       w_done, w_busy, w_err, w_h0_start, w_h1_start, w_h0_fifo_empty, w_h1_fifo_empty, w_fifo_rd;
   logic [1:0] w_rng_start, w_sel;

   keygen_rng_sched #(.RNG_DAT_W(64), .TO_W(20)) dut (
      .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy), .err(err),
      .h0_start(h0_start), .h0_done(h0_done), .h1_start(h1_start), .h1_done(h1_done),
      .h0_fifo_rd(h0_fifo_rd), .h0_rng_start(h0_rng_start), .h0_fifo_empty(h0_fifo_empty),
      .h1_fifo_rd(h1_fifo_rd), .h1_rng_start(h1_rng_start), .h1_fifo_empty(h1_fifo_empty),
      .fifo_rd(fifo_rd), .fifo_empty(fifo_empty), .rng_start(rng_start), .sel(sel));

   // Short watchdog instance sharing the same stimulus.
   keygen_rng_sched #(.RNG_DAT_W(64), .TO_W(4)) dut_wd (
      .clk(clk), .rst(rst), .start(start), .done(w_done), .busy(w_busy), .err(w_err),
      .h0_start(w_h0_start), .h0_done(h0_done), .h1_start(w_h1_start), .h1_done(h1_done),
      .h0_fifo_rd(h0_fifo_rd), .h0_rng_start(h0_rng_start), .h0_fifo_empty(w_h0_fifo_empty),
      .h1_fifo_rd(h1_fifo_rd), .h1_rng_start(h1_rng_start), .h1_fifo_empty(w_h1_fifo_empty),
      .fifo_rd(w_fifo_rd), .fifo_empty(fifo_empty), .rng_start(w_rng_start), .sel(w_sel));

   always #5 clk = ~clk;

   typedef struct {
      int   inst;
      int   cyc;
      logic err;
   } exp_t;
   exp_t exp_q[$];

   int cyc = 0;
   int passed = 0;
   int total = 0;
   int done_cnt = 0, h0s_cnt = 0, w_h1s_cnt = 0;
   logic viol = 1'b0;

   // Pulse counters and exclusivity watch, sampled mid-cycle.
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (h0_start) h0s_cnt++;
      if (w_h1_start) w_h1s_cnt++;
      if ((h0_start && h1_start) || (done && (h0_start || h1_start))) viol = 1'b1;
      if ((w_h0_start && w_h1_start) || (w_done && (w_h0_start || w_h1_start))) viol = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0; h0_done = 1'b0; h1_done = 1'b0;
      h0_fifo_rd = 1'b0; h1_fifo_rd = 1'b0;
      h0_rng_start = 2'd0; h1_rng_start = 2'd0; fifo_empty = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Pop the next expected done event and wait (bounded) for that instance's done.
   task automatic wait_done(input int inst);
      exp_t e;
      int   n;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      n = 0;
      while (!((inst == 0) ? done : w_done) && n < 300) begin
         step();
         n++;
      end
      chk("done_cycle", 32'(cyc), 32'(e.cyc));
      chk("done_err", (inst == 0) ? 32'(err) : 32'(w_err), 32'(e.err));
   endtask

   // Full h0/h1 run with mux isolation checks along the way.
   task automatic run_nominal();
      int t0;
      t0 = cyc;
      start = 1'b1;
      exp_q.push_back('{0, t0 + 122, 1'b0});
      step();
      start = 1'b0;
      chk("t1_h0_start", 32'(h0_start), 32'd1);
      chk("t1_sel_run0", 32'(sel), 32'd1);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_err_clr", 32'(err), 32'd0);
      chk("t1_h1_start_lo", 32'(h1_start), 32'd0);
      run_to(t0 + 20);
      h0_fifo_rd = 1'b1; h0_rng_start = 2'd1; h1_fifo_rd = 1'b1; h1_rng_start = 2'd2; fifo_empty = 1'b0;
      #1;
      chk("t2_rd_h0", 32'(fifo_rd), 32'd1);
      chk("t2_rng_h0", 32'(rng_start), 32'd1);
      chk("t2_h0_empty", 32'(h0_fifo_empty), 32'd0);
      chk("t2_h1_empty", 32'(h1_fifo_empty), 32'd1);
      h0_fifo_rd = 1'b0;
      #1;
      chk("t2_h1_rd_dropped", 32'(fifo_rd), 32'd0);
      h0_fifo_rd = 1'b1;
      run_to(t0 + 50);
      h0_done = 1'b1;
      step();
      h0_done = 1'b0;
      chk("t2_gap_sel", 32'(sel), 32'd0);
      chk("t2_gap_rd", 32'(fifo_rd), 32'd0);
      chk("t2_gap_rng", 32'(rng_start), 32'd0);
      chk("t2_gap_h0_empty", 32'(h0_fifo_empty), 32'd1);
      chk("t2_gap_h1_empty", 32'(h1_fifo_empty), 32'd1);
      chk("t1_gap_h1_start", 32'(h1_start), 32'd0);
      step();
      chk("t1_h1_start", 32'(h1_start), 32'd1);
      chk("t1_sel_run1", 32'(sel), 32'd2);
      chk("t2_rd_h1", 32'(fifo_rd), 32'd1);
      chk("t2_rng_h1", 32'(rng_start), 32'd2);
      chk("t2_run1_h1_empty", 32'(h1_fifo_empty), 32'd0);
      chk("t2_run1_h0_empty", 32'(h0_fifo_empty), 32'd1);
      h1_fifo_rd = 1'b0;
      #1;
      chk("t2_h0_rd_dropped", 32'(fifo_rd), 32'd0);
      h0_fifo_rd = 1'b0; h0_rng_start = 2'd0; h1_rng_start = 2'd0; fifo_empty = 1'b1;
      run_to(t0 + 120);
      h1_done = 1'b1;
      step();
      h1_done = 1'b0;
      chk("t1_fin_busy", 32'(busy), 32'd1);
      chk("t1_fin_no_done", 32'(done), 32'd0);
      chk("t1_fin_sel", 32'(sel), 32'd0);
      wait_done(0);
      chk("t1_idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int t0, dc, hc, wc;

      // Reset state
      do_reset();
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_h0_start", 32'(h0_start), 32'd0);
      chk("rst_h1_start", 32'(h1_start), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_h0_empty", 32'(h0_fifo_empty), 32'd1);

      // T1 + T2
      run_nominal();

      // T3 watchdog in RUN0
      do_reset();
      wc = w_h1s_cnt;
      t0 = cyc;
      start = 1'b1;
      exp_q.push_back('{1, t0 + 17, 1'b1});
      step();
      start = 1'b0;
      run_to(t0 + 15);
      chk("t3_c15_err", 32'(w_err), 32'd0);
      chk("t3_c15_sel", 32'(w_sel), 32'd1);
      step();
      chk("t3_fin_err", 32'(w_err), 32'd1);
      chk("t3_fin_busy", 32'(w_busy), 32'd1);
      chk("t3_fin_no_done", 32'(w_done), 32'd0);
      wait_done(1);
      chk("t3_no_h1_start", 32'(w_h1s_cnt - wc), 32'd0);

      // T4 done/timeout tie in RUN1
      do_reset();
      t0 = cyc;
      start = 1'b1;
      exp_q.push_back('{1, t0 + 21, 1'b0});
      step();
      start = 1'b0;
      run_to(t0 + 3);
      h0_done = 1'b1;
      step();
      h0_done = 1'b0;
      step();
      chk("t4_h1_start", 32'(w_h1_start), 32'd1);
      run_to(t0 + 19);
      h1_done = 1'b1;
      step();
      h1_done = 1'b0;
      chk("t4_fin_err", 32'(w_err), 32'd0);
      wait_done(1);

      // T5 start while busy
      do_reset();
      dc = done_cnt;
      hc = h0s_cnt;
      t0 = cyc;
      start = 1'b1;
      exp_q.push_back('{0, t0 + 14, 1'b0});
      step();
      start = 1'b0;
      run_to(t0 + 2);
      start = 1'b1;
      step();
      start = 1'b0;
      run_to(t0 + 5);
      h0_done = 1'b1;
      step();
      h0_done = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t5_h1_start", 32'(h1_start), 32'd1);
      run_to(t0 + 8);
      start = 1'b1;
      step();
      start = 1'b0;
      run_to(t0 + 12);
      h1_done = 1'b1;
      step();
      h1_done = 1'b0;
      start = 1'b1;
      chk("t5_fin_busy", 32'(busy), 32'd1);
      step();
      start = 1'b0;
      wait_done(0);
      repeat (5) step();
      chk("t5_one_done", 32'(done_cnt - dc), 32'd1);
      chk("t5_one_h0_start", 32'(h0s_cnt - hc), 32'd1);
      chk("t5_idle", 32'(busy), 32'd0);

      // T6 reset mid-RUN1
      do_reset();
      dc = done_cnt;
      t0 = cyc;
      start = 1'b1;
      step();
      start = 1'b0;
      run_to(t0 + 5);
      h0_done = 1'b1;
      step();
      h0_done = 1'b0;
      run_to(t0 + 9);
      chk("t6_in_run1", 32'(sel), 32'd2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_sel", 32'(sel), 32'd0);
      chk("t6_err", 32'(err), 32'd0);
      chk("t6_h1_start", 32'(h1_start), 32'd0);
      repeat (3) step();
      chk("t6_no_done", 32'(done_cnt - dc), 32'd0);
      run_nominal();

      chk("start_done_exclusive", 32'(viol), 32'd0);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
